// File: rtl/riscv_boot_ctrl_pkg.sv
// Shared definitions for the boot/run sequencer: FSM state encoding and the
// status codes reported to the host (also used by the testbench).
package riscv_boot_ctrl_pkg;

    typedef enum logic [2:0] {
        S_HDR_LO = 3'd0,
        S_HDR_HI = 3'd1,
        S_LOAD   = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } boot_state_e;

    localparam logic [2:0] ST_HDR     = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_HALTED  = 3'd3;
    localparam logic [2:0] ST_TIMEOUT = 3'd4;
    localparam logic [2:0] ST_BADLEN  = 3'd5;

endpackage

// File: rtl/riscv_boot_ctrl_packer.sv
// Little-endian 8->32 packer: bytes 0..2 are held, byte 3 completes the word
// combinationally so the caller can register it on the same edge.
module boot_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_i,
    input  logic        accept_i,
    input  logic        clear_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  idx_q;
    logic [23:0] lo_q;

    assign word_o       = {byte_i, lo_q};
    assign word_valid_o = accept_i && (idx_q == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= 2'd0;
            lo_q  <= 24'd0;
        end else if (clear_i) begin
            idx_q <= 2'd0;
        end else if (accept_i) begin
            case (idx_q)
                2'd0:    lo_q[7:0]   <= byte_i;
                2'd1:    lo_q[15:8]  <= byte_i;
                2'd2:    lo_q[23:16] <= byte_i;
                default: ;
            endcase
            idx_q <= idx_q + 2'd1;
        end
    end

endmodule

// File: rtl/riscv_boot_ctrl.sv
// Boot/run sequencer: loads a length-prefixed byte stream into IMEM while the
// core is held in reset, then runs the core until halt or run-cycle timeout.
module riscv_boot_ctrl
    import riscv_boot_ctrl_pkg::*;
#(
    parameter int IMEM_DEPTH     = 256,
    parameter int ADDR_W         = 8,
    parameter int MAX_RUN_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    input  logic              core_halt,
    input  logic              restart,
    output logic [2:0]        status,
    output logic [31:0]       run_cycles
);

    localparam logic [15:0] DEPTH_N    = 16'(IMEM_DEPTH);
    localparam logic [31:0] RUN_LAST   = 32'(MAX_RUN_CYCLES - 1);
    localparam bit          TIMEOUT_EN = (MAX_RUN_CYCLES != 0);

    boot_state_e       state_q;
    logic              s_ready_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_waddr_q;
    logic [31:0]       imem_wdata_q;
    logic              core_rst_q;
    logic [2:0]        status_q;
    logic [31:0]       run_cycles_q;
    logic [15:0]       n_q;
    logic [ADDR_W:0]   word_idx_q;

    logic        accept;
    logic        pack_valid;
    logic [31:0] pack_word;
    logic        last_word;
    logic        load_done;
    logic        timeout_hit;
    logic [15:0] n_hdr_d;
    logic [31:0] run_cycles_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign accept       = s_valid && s_ready_q;
    assign n_hdr_d      = {s_data, n_q[7:0]};
    assign run_cycles_d = sat_inc(run_cycles_q);
    // word_idx is one bit wider than the address so N == 2**ADDR_W terminates
    assign last_word    = pack_valid && ((17'(word_idx_q) + 17'd1) == {1'b0, n_q});
    assign load_done    = (17'(word_idx_q) == {1'b0, n_q});
    assign timeout_hit  = TIMEOUT_EN && (run_cycles_q == RUN_LAST);

    boot_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .byte_i       (s_data),
        .accept_i     (accept && (state_q == S_LOAD)),
        .clear_i      (state_q != S_LOAD),
        .word_o       (pack_word),
        .word_valid_o (pack_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_HDR_LO;
            s_ready_q    <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_waddr_q <= '0;
            imem_wdata_q <= 32'd0;
            core_rst_q   <= 1'b1;
            status_q     <= ST_HDR;
            run_cycles_q <= 32'd0;
            n_q          <= 16'd0;
            word_idx_q   <= '0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                S_HDR_LO: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        n_q[7:0] <= s_data;
                        state_q  <= S_HDR_HI;
                    end
                end
                S_HDR_HI: begin
                    if (accept) begin
                        n_q[15:8]  <= s_data;
                        word_idx_q <= '0;
                        if (n_hdr_d == 16'd0 || n_hdr_d > DEPTH_N) begin
                            state_q   <= S_ERR;
                            status_q  <= ST_BADLEN;
                            s_ready_q <= 1'b0;
                        end else begin
                            state_q  <= S_LOAD;
                            status_q <= ST_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (load_done) begin
                        state_q    <= S_RUN;
                        status_q   <= ST_RUN;
                        core_rst_q <= 1'b0;
                        s_ready_q  <= 1'b0;
                    end else if (pack_valid) begin
                        imem_we_q    <= 1'b1;
                        imem_waddr_q <= word_idx_q[ADDR_W-1:0];
                        imem_wdata_q <= pack_word;
                        word_idx_q   <= word_idx_q + 1'b1;
                        // no further bytes while the final word is being written
                        if (last_word) begin
                            s_ready_q <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    run_cycles_q <= run_cycles_d;
                    if (core_halt) begin
                        state_q    <= S_DONE;
                        status_q   <= ST_HALTED;
                        core_rst_q <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q    <= S_ERR;
                        status_q   <= ST_TIMEOUT;
                        core_rst_q <= 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    if (restart) begin
                        state_q      <= S_HDR_LO;
                        status_q     <= ST_HDR;
                        run_cycles_q <= 32'd0;
                        s_ready_q    <= 1'b1;
                    end
                end
                default: state_q <= S_HDR_LO;
            endcase
        end
    end

    assign s_ready    = s_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_waddr = imem_waddr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign status     = status_q;
    assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// Directed bench for riscv_boot_ctrl: load, run, halt, timeout, bad length,
// restart, async reset and ignored-control scenarios.
module tb_riscv_boot_ctrl;
    import riscv_boot_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        core_halt = 1'b0;
    logic        restart = 1'b0;

    logic        s_ready, imem_we, core_rst;
    logic [7:0]  imem_waddr;
    logic [31:0] imem_wdata, run_cycles;
    logic [2:0]  status;

    logic        u_s_ready, u_imem_we, u_core_rst;
    logic [7:0]  u_imem_waddr;
    logic [31:0] u_imem_wdata, u_run_cycles;
    logic [2:0]  u_status;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  prog[$];
    logic [7:0]  wa_q[$];
    logic [31:0] wd_q[$];

    riscv_boot_ctrl #(.IMEM_DEPTH(256), .ADDR_W(8), .MAX_RUN_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .core_rst(core_rst), .core_halt(core_halt), .restart(restart),
        .status(status), .run_cycles(run_cycles)
    );

    riscv_boot_ctrl #(.IMEM_DEPTH(256), .ADDR_W(8), .MAX_RUN_CYCLES(0)) dut_unl (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(u_s_ready),
        .imem_we(u_imem_we), .imem_waddr(u_imem_waddr), .imem_wdata(u_imem_wdata),
        .core_rst(u_core_rst), .core_halt(core_halt), .restart(restart),
        .status(u_status), .run_cycles(u_run_cycles)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && imem_we) begin
            wa_q.push_back(imem_waddr);
            wd_q.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_valid = 1'b1;
        s_data  = b;
        forever begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1 s_valid = 1'b0;
                return;
            end
            n++;
            if (n > 50) begin
                chk("s_ready_timeout", {31'd0, s_ready}, 32'd1);
                s_valid = 1'b0;
                return;
            end
        end
    endtask

    task automatic send_prog(input int gap_max);
        foreach (prog[i]) begin
            if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(posedge clk);
            #1 send_byte(prog[i]);
        end
    endtask

    task automatic wait_run();
        int n = 0;
        while (core_rst !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("enter_run", {31'd0, core_rst}, 32'd0);
    endtask

    task automatic halt_after(input int k);
        repeat (k - 1) @(posedge clk);
        #1 core_halt = 1'b1;
        @(posedge clk);
        #1 core_halt = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
    endtask

    task automatic clear_writes();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
        chk({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
        chk({tag, "_waddr"}, {24'd0, imem_waddr}, 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_core_rst"}, {31'd0, core_rst}, 32'd1);
        chk({tag, "_status"}, {29'd0, status}, {29'd0, ST_HDR});
        chk({tag, "_run_cycles"}, run_cycles, 32'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b1;
        #3;
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Scenario 1: two-word program, write timing and core_rst release
        clear_writes();
        prog = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h73, 8'h00, 8'h10, 8'h00};
        send_prog(0);
        @(negedge clk);
        chk("t1_we2", {31'd0, imem_we}, 32'd1);
        chk("t1_waddr2", {24'd0, imem_waddr}, 32'd1);
        chk("t1_wdata2", imem_wdata, 32'h0010_0073);
        chk("t1_sready_wr", {31'd0, s_ready}, 32'd0);
        chk("t1_corerst_wr", {31'd0, core_rst}, 32'd1);
        @(negedge clk);
        chk("t1_corerst_fall", {31'd0, core_rst}, 32'd0);
        chk("t1_status_run", {29'd0, status}, {29'd0, ST_RUN});

        // Scenario 2: halt seven cycles into the run
        halt_after(7);
        chk("t2_status", {29'd0, status}, {29'd0, ST_HALTED});
        chk("t2_run_cycles", run_cycles, 32'd7);
        chk("t2_core_rst", {31'd0, core_rst}, 32'd1);
        chk("t2_s_ready", {31'd0, s_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("t2_run_hold", run_cycles, 32'd7);
        chk("t1_nwrites", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            chk("t1_addr0", {24'd0, wa_q[0]}, 32'd0);
            chk("t1_data0", wd_q[0], 32'h00A0_0513);
            chk("t1_addr1", {24'd0, wa_q[1]}, 32'd1);
            chk("t1_data1", wd_q[1], 32'h0010_0073);
        end

        // Scenario 3: bad lengths, then a full-depth load
        clear_writes();
        pulse_restart();
        chk("t3_restart_status", {29'd0, status}, {29'd0, ST_HDR});
        chk("t3_restart_sready", {31'd0, s_ready}, 32'd1);
        chk("t3_restart_run", run_cycles, 32'd0);
        prog = '{8'h00, 8'h00};
        send_prog(0);
        chk("t3_zero_status", {29'd0, status}, {29'd0, ST_BADLEN});
        chk("t3_zero_sready", {31'd0, s_ready}, 32'd0);
        chk("t3_zero_corerst", {31'd0, core_rst}, 32'd1);
        pulse_restart();
        prog = '{8'h01, 8'h01};
        send_prog(0);
        chk("t3_big_status", {29'd0, status}, {29'd0, ST_BADLEN});
        repeat (3) @(posedge clk);
        #1 chk("t3_big_corerst", {31'd0, core_rst}, 32'd1);
        chk("t3_no_writes", 32'(wa_q.size()), 32'd0);
        pulse_restart();
        chk("t3_restart2_status", {29'd0, status}, {29'd0, ST_HDR});
        prog = '{8'h00, 8'h01};
        for (int i = 0; i < 256; i++) begin
            prog.push_back(8'(i));
            prog.push_back(8'h5A);
            prog.push_back(~8'(i));
            prog.push_back(8'hC3);
        end
        send_prog(0);
        wait_run();
        chk("t3_full_nwrites", 32'(wa_q.size()), 32'd256);
        if (wa_q.size() == 256) begin
            chk("t3_full_data0", wd_q[0], 32'hC3FF_5A00);
            chk("t3_full_addr255", {24'd0, wa_q[255]}, 32'd255);
            chk("t3_full_data255", wd_q[255], 32'hC300_5AFF);
        end
        halt_after(2);
        chk("t3_full_halt", {29'd0, status}, {29'd0, ST_HALTED});

        // Scenario 4: timeout at 16 cycles, unlimited twin keeps running
        pulse_restart();
        prog = '{8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
        send_prog(0);
        wait_run();
        repeat (15) @(posedge clk);
        #1 chk("t4_before_to", {29'd0, status}, {29'd0, ST_RUN});
        chk("t4_run15", run_cycles, 32'd15);
        @(posedge clk);
        #1 chk("t4_to_status", {29'd0, status}, {29'd0, ST_TIMEOUT});
        chk("t4_to_run", run_cycles, 32'd16);
        chk("t4_to_corerst", {31'd0, core_rst}, 32'd1);
        chk("t4_unl_status", {29'd0, u_status}, {29'd0, ST_RUN});
        chk("t4_unl_corerst", {31'd0, u_core_rst}, 32'd0);
        core_halt = 1'b1;
        @(posedge clk);
        #1 core_halt = 1'b0;
        chk("t4_unl_halt", {29'd0, u_status}, {29'd0, ST_HALTED});
        chk("t4_unl_run", u_run_cycles, 32'd17);
        chk("t4_halt_ignored", {29'd0, status}, {29'd0, ST_TIMEOUT});
        pulse_restart();
        send_prog(0);
        wait_run();
        halt_after(16);
        chk("t4_halt16_status", {29'd0, status}, {29'd0, ST_HALTED});
        chk("t4_halt16_run", run_cycles, 32'd16);

        // Scenario 5: gapped stream, then async reset mid-load
        clear_writes();
        pulse_restart();
        prog = '{8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h12, 8'h13, 8'h14,
                 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hF0, 8'hE0, 8'hD0, 8'hC0};
        send_prog(3);
        wait_run();
        chk("t5_nwrites", 32'(wa_q.size()), 32'd4);
        if (wa_q.size() == 4) begin
            chk("t5_addr3", {24'd0, wa_q[3]}, 32'd3);
            chk("t5_data0", wd_q[0], 32'h0403_0201);
            chk("t5_data1", wd_q[1], 32'h1413_1211);
            chk("t5_data2", wd_q[2], 32'hA4A3_A2A1);
            chk("t5_data3", wd_q[3], 32'hC0D0_E0F0);
        end
        halt_after(3);
        pulse_restart();
        prog = '{8'h02, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55, 8'h66};
        send_prog(0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk_reset_outputs("t5_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        clear_writes();
        prog = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        send_prog(0);
        wait_run();
        chk("t5_fresh_nwrites", 32'(wa_q.size()), 32'd1);
        if (wa_q.size() == 1) begin
            chk("t5_fresh_addr", {24'd0, wa_q[0]}, 32'd0);
            chk("t5_fresh_data", wd_q[0], 32'h4433_2211);
        end
        halt_after(2);

        // Scenario 6: restart/halt pulses where they must be ignored
        clear_writes();
        pulse_restart();
        prog = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
        send_prog(0);
        restart   = 1'b1;
        core_halt = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
        core_halt = 1'b0;
        chk("t6_load_status", {29'd0, status}, {29'd0, ST_LOAD});
        chk("t6_load_sready", {31'd0, s_ready}, 32'd1);
        prog = '{8'h73, 8'h00, 8'h10, 8'h00};
        send_prog(0);
        wait_run();
        pulse_restart();
        chk("t6_run_status", {29'd0, status}, {29'd0, ST_RUN});
        halt_after(3);
        chk("t6_done_status", {29'd0, status}, {29'd0, ST_HALTED});
        chk("t6_done_run", run_cycles, 32'd4);
        chk("t6_nwrites", 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            chk("t6_data0", wd_q[0], 32'h00A0_0513);
            chk("t6_data1", wd_q[1], 32'h0010_0073);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
